// File: rtl/mano_datapath.sv
// Mano basic-computer datapath.
// Holds the AR, PC, DR, AC, IR, TR and E registers, the 16-bit common bus with
// its one-hot source select, the AC/E ALU, and the external memory interface.
// The control unit drives one register transfer per clock.
module mano_datapath #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  // register increment / load strobes
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic              ir_inc,
  input  logic              ir_load,
  input  logic              ar_inc,
  input  logic              ar_load,
  input  logic              dr_inc,
  input  logic              dr_load,
  input  logic              tr_load,
  // ALU commit and op select
  input  logic              ac_enable,
  input  logic              alu_and,
  input  logic              alu_add,
  input  logic              alu_lda,
  input  logic              alu_cla,
  input  logic              alu_cle,
  input  logic              alu_cma,
  input  logic              alu_cme,
  input  logic              alu_cir,
  input  logic              alu_cil,
  input  logic              alu_inc,
  // bus source select (one-hot)
  input  logic              pc_sel,
  input  logic              ar_sel,
  input  logic              dr_sel,
  input  logic              mem_sel,
  input  logic              ac_sel,
  input  logic              ir_sel,
  input  logic              tr_sel,
  // memory interface
  input  logic              mem_read,
  input  logic              mem_wrt,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  // register contents to the control unit
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] ac,
  output logic [DATA_W-1:0] dr,
  output logic              E,
  // debug visibility
  output logic [ADDR_W-1:0] ar,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] bus,
  output logic              sel_conflict,
  output logic              alu_conflict
);

  localparam int ZEXT_W = DATA_W - ADDR_W;

  // architectural registers
  logic [ADDR_W-1:0] ar_q, ar_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] dr_q, dr_d;
  logic [DATA_W-1:0] ac_q, ac_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] tr_q, tr_d;
  logic              e_q,  e_d;

  logic [DATA_W-1:0] bus_w;
  logic [DATA_W:0]   sum_w;
  logic [6:0]        sel_vec;
  logic [9:0]        op_vec;

  // Common bus mux: fixed priority mem > ac > ir > tr > dr > pc > ar.
  // A memory source without mem_read drives zero rather than stale data.
  always_comb begin
    bus_w = '0;
    if (mem_sel) begin
      bus_w = mem_read ? mem_rdata : '0;
    end else if (ac_sel) begin
      bus_w = ac_q;
    end else if (ir_sel) begin
      bus_w = ir_q;
    end else if (tr_sel) begin
      bus_w = tr_q;
    end else if (dr_sel) begin
      bus_w = dr_q;
    end else if (pc_sel) begin
      bus_w = {{ZEXT_W{1'b0}}, pc_q};
    end else if (ar_sel) begin
      bus_w = {{ZEXT_W{1'b0}}, ar_q};
    end
  end

  // Conflict detection: a vector with more than one bit set has v & (v-1) != 0.
  assign sel_vec = {pc_sel, ar_sel, dr_sel, mem_sel, ac_sel, ir_sel, tr_sel};
  assign op_vec  = {alu_and, alu_add, alu_lda, alu_cla, alu_cle,
                    alu_cma, alu_cme, alu_cir, alu_cil, alu_inc};

  always_comb begin
    sel_conflict = ((sel_vec & (sel_vec - 7'd1)) != 7'd0);
    alu_conflict = ac_enable &&
                   ((op_vec == 10'd0) || ((op_vec & (op_vec - 10'd1)) != 10'd0));
  end

  // ALU next state for AC/E; the first op in list order wins when several are high.
  always_comb begin
    ac_d  = ac_q;
    e_d   = e_q;
    sum_w = {1'b0, ac_q} + {1'b0, dr_q};
    if (ac_enable) begin
      if (alu_and) begin
        ac_d = ac_q & dr_q;
      end else if (alu_add) begin
        ac_d = sum_w[DATA_W-1:0];
        e_d  = sum_w[DATA_W];
      end else if (alu_lda) begin
        ac_d = dr_q;
      end else if (alu_cla) begin
        ac_d = '0;
      end else if (alu_cle) begin
        e_d  = 1'b0;
      end else if (alu_cma) begin
        ac_d = ~ac_q;
      end else if (alu_cme) begin
        e_d  = ~e_q;
      end else if (alu_cir) begin
        ac_d = {e_q, ac_q[DATA_W-1:1]};
        e_d  = ac_q[0];
      end else if (alu_cil) begin
        ac_d = {ac_q[DATA_W-2:0], e_q};
        e_d  = ac_q[DATA_W-1];
      end else if (alu_inc) begin
        ac_d = ac_q + 1'b1;
      end
    end
  end

  // Register next state: load beats increment; increments wrap naturally.
  // Loads read the pre-edge bus, so a register may reload its own old value.
  always_comb begin
    ar_d = ar_load ? bus_w[ADDR_W-1:0] : (ar_inc ? ar_q + 1'b1 : ar_q);
    pc_d = pc_load ? bus_w[ADDR_W-1:0] : (pc_inc ? pc_q + 1'b1 : pc_q);
    dr_d = dr_load ? bus_w : (dr_inc ? dr_q + 1'b1 : dr_q);
    ir_d = ir_load ? bus_w : (ir_inc ? ir_q + 1'b1 : ir_q);
    tr_d = tr_load ? bus_w : tr_q;
  end

  // State registers; asynchronous reset clears everything and drops the transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ar_q <= '0;
      pc_q <= '0;
      dr_q <= '0;
      ac_q <= '0;
      ir_q <= '0;
      tr_q <= '0;
      e_q  <= 1'b0;
    end else begin
      ar_q <= ar_d;
      pc_q <= pc_d;
      dr_q <= dr_d;
      ac_q <= ac_d;
      ir_q <= ir_d;
      tr_q <= tr_d;
      e_q  <= e_d;
    end
  end

  // Outputs: memory write is suppressed for as long as reset is asserted.
  assign mem_addr  = ar_q;
  assign mem_wdata = bus_w;
  assign mem_we    = mem_wrt & ~rst;
  assign bus       = bus_w;
  assign ir        = ir_q;
  assign ac        = ac_q;
  assign dr        = dr_q;
  assign E         = e_q;
  assign ar        = ar_q;
  assign pc        = pc_q;

endmodule

// File: tb/tb_mano_datapath.sv
// Directed bench for mano_datapath with a small external memory model.
module tb_mano_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_inc, pc_load, ir_inc, ir_load, ar_inc, ar_load;
  logic        dr_inc, dr_load, tr_load, ac_enable;
  logic        alu_and, alu_add, alu_lda, alu_cla, alu_cle;
  logic        alu_cma, alu_cme, alu_cir, alu_cil, alu_inc;
  logic        pc_sel, ar_sel, dr_sel, mem_sel, ac_sel, ir_sel, tr_sel;
  logic        mem_read, mem_wrt;
  logic [15:0] mem_rdata;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] ir, ac, dr, bus;
  logic        E;
  logic [11:0] ar, pc;
  logic        sel_conflict, alu_conflict;

  // memory model: array written only by the DUT; bench can override the read data
  logic [15:0] mem [0:4095];
  logic        drive_ovr;
  logic [15:0] drive_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign mem_rdata = drive_ovr ? drive_val : mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  mano_datapath #(.DATA_W(16), .ADDR_W(12)) dut (
    .clk(clk), .rst(rst),
    .pc_inc(pc_inc), .pc_load(pc_load), .ir_inc(ir_inc), .ir_load(ir_load),
    .ar_inc(ar_inc), .ar_load(ar_load), .dr_inc(dr_inc), .dr_load(dr_load),
    .tr_load(tr_load), .ac_enable(ac_enable),
    .alu_and(alu_and), .alu_add(alu_add), .alu_lda(alu_lda), .alu_cla(alu_cla),
    .alu_cle(alu_cle), .alu_cma(alu_cma), .alu_cme(alu_cme), .alu_cir(alu_cir),
    .alu_cil(alu_cil), .alu_inc(alu_inc),
    .pc_sel(pc_sel), .ar_sel(ar_sel), .dr_sel(dr_sel), .mem_sel(mem_sel),
    .ac_sel(ac_sel), .ir_sel(ir_sel), .tr_sel(tr_sel),
    .mem_read(mem_read), .mem_wrt(mem_wrt), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .ir(ir), .ac(ac), .dr(dr), .E(E), .ar(ar), .pc(pc), .bus(bus),
    .sel_conflict(sel_conflict), .alu_conflict(alu_conflict)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    {pc_inc, pc_load, ir_inc, ir_load, ar_inc, ar_load, dr_inc, dr_load, tr_load} = '0;
    ac_enable = 1'b0;
    {alu_and, alu_add, alu_lda, alu_cla, alu_cle} = '0;
    {alu_cma, alu_cme, alu_cir, alu_cil, alu_inc} = '0;
    {pc_sel, ar_sel, dr_sel, mem_sel, ac_sel, ir_sel, tr_sel} = '0;
    mem_read  = 1'b0;
    mem_wrt   = 1'b0;
    drive_ovr = 1'b0;
    drive_val = 16'h0000;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  // put a value on the bus through the memory read path
  task automatic feed(input logic [15:0] v);
    drive_ovr = 1'b1;
    drive_val = v;
    mem_sel   = 1'b1;
    mem_read  = 1'b1;
  endtask

  task automatic load_dr(input logic [15:0] v);
    feed(v); dr_load = 1'b1; step();
  endtask

  task automatic load_ac(input logic [15:0] v);
    load_dr(v); alu_lda = 1'b1; ac_enable = 1'b1; step();
  endtask

  task automatic load_pc(input logic [15:0] v);
    feed(v); pc_load = 1'b1; step();
  endtask

  task automatic load_ar(input logic [15:0] v);
    feed(v); ar_load = 1'b1; step();
  endtask

  task automatic load_tr(input logic [15:0] v);
    feed(v); tr_load = 1'b1; step();
  endtask

  task automatic set_e(input logic b);
    alu_cle = 1'b1; ac_enable = 1'b1; step();
    if (b) begin
      alu_cme = 1'b1; ac_enable = 1'b1; step();
    end
  endtask

  initial begin
    clr();
    rst = 1'b1;
    #12;
    // power-on reset
    check_eq("rst_ac", ac, 16'h0);
    check_eq("rst_pc", pc, 12'h0);
    check_eq("rst_E", E, 1'b0);
    check_eq("rst_bus", bus, 16'h0);
    mem_wrt = 1'b1;
    #1;
    check_eq("rst_mem_we", mem_we, 1'b0);
    mem_wrt = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // reset asserted between edges while a transfer is set up
    load_ac(16'h1234);
    load_pc(16'h0005);
    check_eq("pre_ac", ac, 16'h1234);
    check_eq("pre_pc", pc, 12'h005);
    #2;
    pc_inc = 1'b1; mem_wrt = 1'b1; rst = 1'b1;
    #1;
    check_eq("mid_rst_ac", ac, 16'h0);
    check_eq("mid_rst_pc", pc, 12'h0);
    check_eq("mid_rst_dr", dr, 16'h0);
    check_eq("mid_rst_E", E, 1'b0);
    check_eq("mid_rst_mem_we", mem_we, 1'b0);
    @(posedge clk); #1;
    check_eq("rst_hold_pc", pc, 12'h0);
    check_eq("rst_hold_mem_we", mem_we, 1'b0);
    rst = 1'b0;
    clr();

    // instruction fetch
    load_pc(16'h0010);
    pc_sel = 1'b1; ar_load = 1'b1; step();
    check_eq("fetch_ar", ar, 12'h010);
    feed(16'h7800); ir_load = 1'b1; pc_inc = 1'b1;
    #1;
    check_eq("fetch_addr", mem_addr, 12'h010);
    step();
    check_eq("fetch_ir", ir, 16'h7800);
    check_eq("fetch_pc", pc, 12'h011);
    pc_sel = 1'b1; #1;
    check_eq("pc_zext_bus", bus, 16'h0011);
    clr();
    drive_ovr = 1'b1; drive_val = 16'hAAAA; mem_sel = 1'b1; #1;
    check_eq("mem_noread_bus", bus, 16'h0000);
    clr();
    #1;
    check_eq("nosel_bus", bus, 16'h0000);

    // add with carry out, then rotate left
    load_ac(16'hFFFF);
    load_dr(16'h0001);
    set_e(1'b0);
    alu_add = 1'b1; ac_enable = 1'b1; step();
    check_eq("add_ac", ac, 16'h0000);
    check_eq("add_E", E, 1'b1);
    alu_cil = 1'b1; ac_enable = 1'b1; step();
    check_eq("cil_ac", ac, 16'h0001);
    check_eq("cil_E", E, 1'b0);

    // rotate right and increment
    load_ac(16'h0003);
    set_e(1'b1);
    alu_cir = 1'b1; ac_enable = 1'b1; step();
    check_eq("cir_ac", ac, 16'h8001);
    check_eq("cir_E", E, 1'b1);
    load_ac(16'hFFFF);
    alu_inc = 1'b1; ac_enable = 1'b1; step();
    check_eq("inc_ac", ac, 16'h0000);
    check_eq("inc_E", E, 1'b1);
    alu_cma = 1'b1; ac_enable = 1'b1; step();
    check_eq("cma_ac", ac, 16'hFFFF);

    // wrap-around and load-over-increment
    load_pc(16'h0FFF);
    pc_inc = 1'b1; step();
    check_eq("pc_wrap", pc, 12'h000);
    feed(16'h0ABC); ar_load = 1'b1; ar_inc = 1'b1;
    #1;
    check_eq("ar_bus", bus, 16'h0ABC);
    step();
    check_eq("ar_load_wins", ar, 12'hABC);
    load_dr(16'hFFFF);
    dr_inc = 1'b1; step();
    check_eq("dr_wrap", dr, 16'h0000);
    load_dr(16'h5A5A);
    dr_sel = 1'b1; dr_load = 1'b1; dr_inc = 1'b1; step();
    check_eq("dr_self_load", dr, 16'h5A5A);

    // bus and ALU conflicts
    load_ac(16'h1111);
    load_dr(16'h2222);
    ac_sel = 1'b1; dr_sel = 1'b1; #1;
    check_eq("conf_bus", bus, 16'h1111);
    check_eq("sel_conflict", sel_conflict, 1'b1);
    clr(); dr_sel = 1'b1; #1;
    check_eq("sel_single", sel_conflict, 1'b0);
    check_eq("dr_bus", bus, 16'h2222);
    clr();
    load_ac(16'h00FF);
    load_dr(16'h0F0F);
    alu_and = 1'b1; alu_cla = 1'b1; ac_enable = 1'b1; #1;
    check_eq("alu_conflict_multi", alu_conflict, 1'b1);
    step();
    check_eq("and_priority_ac", ac, 16'h000F);
    ac_enable = 1'b1; #1;
    check_eq("alu_conflict_none", alu_conflict, 1'b1);
    step();
    check_eq("noop_hold_ac", ac, 16'h000F);
    alu_cma = 1'b1; #1;
    check_eq("alu_conflict_off", alu_conflict, 1'b0);
    step();
    check_eq("no_enable_ac", ac, 16'h000F);

    // memory write from TR at address AR, then read back
    load_tr(16'hBEEF);
    load_ar(16'h0020);
    tr_sel = 1'b1; mem_wrt = 1'b1; #1;
    check_eq("wr_mem_we", mem_we, 1'b1);
    check_eq("wr_wdata", mem_wdata, 16'hBEEF);
    check_eq("wr_addr", mem_addr, 12'h020);
    step();
    check_eq("wr_mem", mem[12'h020], 16'hBEEF);
    mem_sel = 1'b1; mem_read = 1'b1; dr_load = 1'b1; step();
    check_eq("rd_dr", dr, 16'hBEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // hard bound on run time
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
